// File: rtl/invtran_sched_if.sv
// Handshake bundle between invtran_sched and its neighbours:
// coefficient buffer (coef_*), inverse transform (tran_enable),
// residual buffer (res_*), and macroblock control (start/cbp/abort).
// slave  : sequencer side (drives requests, strobes and writes)
// master : environment side (drives start/cbp/abort/coef_vld/res_ready)
interface invtran_sched_if #(
    parameter int BLOCKS = 16,
    parameter int IDX_W  = 4
);
    logic              start;
    logic [BLOCKS-1:0] cbp;
    logic              abort;
    logic              coef_req;
    logic [IDX_W-1:0]  coef_idx;
    logic              coef_vld;
    logic              tran_enable;
    logic              res_ready;
    logic              res_wr;
    logic [IDX_W-1:0]  res_idx;
    logic              res_zero;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output cbp,
        output abort,
        output coef_vld,
        output res_ready,
        input  coef_req,
        input  coef_idx,
        input  tran_enable,
        input  res_wr,
        input  res_idx,
        input  res_zero,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  cbp,
        input  abort,
        input  coef_vld,
        input  res_ready,
        output coef_req,
        output coef_idx,
        output tran_enable,
        output res_wr,
        output res_idx,
        output res_zero,
        output busy,
        output done
    );
endinterface

// File: rtl/invtran_sched.sv
// Inverse-transform sequencer: walks BLOCKS 4x4 blocks in raster order,
// issues coded blocks to the transform, writes residuals in issue order.
// Ports: clk, reset (async, active-high), bus (invtran_sched_if.slave):
//   start/cbp/abort control, coef_req/coef_idx/coef_vld fetch,
//   tran_enable issue, res_ready/res_wr/res_idx/res_zero write,
//   busy/done status.
module invtran_sched #(
    parameter int BLOCKS = 16,
    parameter int LAT    = 1,
    parameter int IDX_W  = 4
) (
    input logic            clk,
    input logic            reset,
    invtran_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCKS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [BLOCKS-1:0] cbp_q, cbp_d;

    // Result pipeline: {valid, zero, index} per stage; stage LAT-1 is
    // the write port.  Zero blocks ride it too so order is preserved.
    logic [LAT-1:0]            v_q, v_d;
    logic [LAT-1:0]            z_q, z_d;
    logic [LAT-1:0][IDX_W-1:0] idx_q, idx_d;

    logic cur_coded;
    logic push;
    logic push_z;
    logic req;
    logic ten;
    logic done_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            cbp_q   <= '0;
            v_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cbp_q   <= cbp_d;
            v_q     <= v_d;
            z_q     <= z_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cbp_d     = cbp_q;
        cur_coded = cbp_q[n_q];
        push      = 1'b0;
        push_z    = 1'b0;
        req       = 1'b0;
        ten       = 1'b0;
        done_p    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    cbp_d   = bus.cbp;
                    n_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                req = cur_coded;
                // Coded blocks need data and sink room; skipped
                // blocks need sink room only.
                if (!bus.abort && bus.res_ready &&
                    (bus.coef_vld || !cur_coded)) begin
                    push   = 1'b1;
                    push_z = !cur_coded;
                    ten    = cur_coded;
                    if (n_q == LAST) begin
                        n_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!(|v_q) && !bus.abort) begin
                    done_p  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort) begin
            state_d = IDLE;
            n_d     = '0;
        end
    end

    always_comb begin
        v_d      = '0;
        z_d      = '0;
        idx_d    = '0;
        v_d[0]   = push;
        z_d[0]   = push_z;
        idx_d[0] = push ? n_q : '0;
        for (int i = 1; i < LAT; i++) begin
            v_d[i]   = v_q[i-1];
            z_d[i]   = z_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
        // Abort drops everything still in flight; the write already
        // on the port this cycle stands.
        if (bus.abort) begin
            v_d = '0;
        end
    end

    assign bus.coef_req    = req;
    assign bus.coef_idx    = req ? n_q : '0;
    assign bus.tran_enable = ten;
    assign bus.res_wr      = v_q[LAT-1];
    assign bus.res_zero    = v_q[LAT-1] & z_q[LAT-1];
    assign bus.res_idx     = v_q[LAT-1] ? idx_q[LAT-1] : '0;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_p;

endmodule

// File: tb/tb_invtran_sched.sv
// Bench for invtran_sched: LAT=1 and LAT=2 instances share stimulus;
// expected writes are queued per instance and checked every cycle.
module tb_invtran_sched;

    localparam int BLOCKS = 16;
    localparam int IDX_W  = 4;

    typedef struct {
        int               c;
        logic             z;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   dn1   = -1;
    int   dn2   = -1;
    exp_t q1[$];
    exp_t q2[$];

    invtran_sched_if #(.BLOCKS(BLOCKS), .IDX_W(IDX_W)) i1 ();
    invtran_sched_if #(.BLOCKS(BLOCKS), .IDX_W(IDX_W)) i2 ();

    assign i2.start     = i1.start;
    assign i2.cbp       = i1.cbp;
    assign i2.abort     = i1.abort;
    assign i2.coef_vld  = i1.coef_vld;
    assign i2.res_ready = i1.res_ready;

    invtran_sched #(.BLOCKS(BLOCKS), .LAT(1), .IDX_W(IDX_W)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (i1.slave)
    );

    invtran_sched #(.BLOCKS(BLOCKS), .LAT(2), .IDX_W(IDX_W)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (i2.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h cyc=%0d", tag, o, x, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle write/done monitor for both latencies.
    always @(negedge clk) begin
        bit e;
        if (!reset) begin
            e = q1.size() > 0 && q1[0].c == cyc;
            chk("wr_l1", i1.res_wr, e);
            if (e) begin
                chk("idx_l1", i1.res_idx, q1[0].idx);
                chk("zero_l1", i1.res_zero, q1[0].z);
                void'(q1.pop_front());
            end
            chk("done_l1", i1.done, cyc == dn1);
            e = q2.size() > 0 && q2[0].c == cyc;
            chk("wr_l2", i2.res_wr, e);
            if (e) begin
                chk("idx_l2", i2.res_idx, q2[0].idx);
                chk("zero_l2", i2.res_zero, q2[0].z);
                void'(q2.pop_front());
            end
            chk("done_l2", i2.done, cyc == dn2);
        end
    end

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_req"}, i1.coef_req, 0);
        chk({tag, "_cidx"}, i1.coef_idx, 0);
        chk({tag, "_ten"}, i1.tran_enable, 0);
        chk({tag, "_wr1"}, i1.res_wr, 0);
        chk({tag, "_ridx1"}, i1.res_idx, 0);
        chk({tag, "_rz1"}, i1.res_zero, 0);
        chk({tag, "_busy1"}, i1.busy, 0);
        chk({tag, "_done1"}, i1.done, 0);
        chk({tag, "_wr2"}, i2.res_wr, 0);
        chk({tag, "_busy2"}, i2.busy, 0);
    endtask

    // One macroblock. sblk/sn: stall block and length (srdy selects
    // res_ready low vs coef_vld low). ab: abort after pushing block ab.
    // rd: assert reset one cycle into DRAIN.
    task automatic run_mb(input logic [15:0] m, input int sblk,
                          input int sn, input bit srdy, input int ab,
                          input bit rd);
        int a;
        step();
        i1.start     = 1'b1;
        i1.cbp       = m;
        i1.coef_vld  = 1'b1;
        i1.res_ready = 1'b1;
        for (int n = 0; n < BLOCKS; n++) begin
            if (n == sblk) begin
                for (int k = 0; k < sn; k++) begin
                    step();
                    i1.start = 1'b1;
                    if (srdy) i1.res_ready = 1'b0;
                    else i1.coef_vld = 1'b0;
                    @(negedge clk);
                    chk("stall_req", i1.coef_req, m[n]);
                    if (m[n]) chk("stall_cidx", i1.coef_idx, n);
                    chk("stall_ten", i1.tran_enable, 0);
                    chk("stall_busy", i1.busy, 1);
                end
            end
            step();
            i1.start     = 1'b0;
            i1.coef_vld  = 1'b1;
            i1.res_ready = 1'b1;
            q1.push_back('{c: cyc + 1, z: !m[n], idx: n[3:0]});
            q2.push_back('{c: cyc + 2, z: !m[n], idx: n[3:0]});
            if (n == BLOCKS - 1) begin
                dn1 = cyc + 2;
                dn2 = cyc + 3;
            end
            @(negedge clk);
            chk("req", i1.coef_req, m[n]);
            if (m[n]) chk("cidx", i1.coef_idx, n);
            chk("ten_l1", i1.tran_enable, m[n]);
            chk("ten_l2", i2.tran_enable, m[n]);
            chk("busy_l1", i1.busy, 1);
            if (n == ab) begin
                step();
                i1.abort = 1'b1;
                a = cyc;
                while (q1.size() > 0 && q1[q1.size()-1].c > a)
                    void'(q1.pop_back());
                while (q2.size() > 0 && q2[q2.size()-1].c > a)
                    void'(q2.pop_back());
                dn1 = -1;
                dn2 = -1;
                step();
                i1.abort = 1'b0;
                @(negedge clk);
                chk("ab_busy1", i1.busy, 0);
                chk("ab_busy2", i2.busy, 0);
                chk("ab_req", i1.coef_req, 0);
                return;
            end
        end
        if (rd) begin
            @(posedge clk);
            #2 reset = 1'b1;
            #1;
            chk_zero_outs("rst");
            q1.delete();
            q2.delete();
            dn1 = -1;
            dn2 = -1;
            step();
            reset = 1'b0;
            return;
        end
        repeat (4) step();
        @(negedge clk);
        chk("end_busy1", i1.busy, 0);
        chk("end_busy2", i2.busy, 0);
    endtask

    initial begin
        i1.start     = 1'b0;
        i1.cbp       = '0;
        i1.abort     = 1'b0;
        i1.coef_vld  = 1'b0;
        i1.res_ready = 1'b0;
        @(negedge clk);
        chk_zero_outs("init");
        step();
        reset = 1'b0;
        run_mb(16'hFFFF, -1, 0, 1'b0, -1, 1'b0);
        run_mb(16'h0000, -1, 0, 1'b0, -1, 1'b0);
        run_mb(16'h00F0, 4, 3, 1'b0, -1, 1'b0);
        run_mb(16'hFFFF, 7, 5, 1'b1, -1, 1'b0);
        run_mb(16'hFFFF, -1, 0, 1'b0, 9, 1'b0);
        run_mb(16'hFFFF, -1, 0, 1'b0, -1, 1'b0);
        run_mb(16'hA5C3, -1, 0, 1'b0, -1, 1'b1);
        step();
        i1.start = 1'b1;
        i1.cbp   = 16'hFFFF;
        i1.abort = 1'b1;
        step();
        i1.start = 1'b0;
        i1.abort = 1'b0;
        @(negedge clk);
        chk("sa_busy1", i1.busy, 0);
        chk("sa_busy2", i2.busy, 0);
        chk("sa_req", i1.coef_req, 0);
        repeat (3) step();
        @(negedge clk);
        chk("sa_busy_late", i1.busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
